stack_calc: RTL and testbench
=============================

// Module: stack_calc
// PURPOSE
//  Parametrised successor to the opcode-driven stack: LIFO of DEPTH signed WIDTH-bit words with
//  in-place ALU ops (ADD/SUB/MUL/DUP/SWAP). Ops are accepted via a valid/ready handshake.
//  MUL is a serial multi-cycle operation; every completed op pulses done with error/overflow.
//  Used as the expression-evaluation engine behind the command decoder.
// PARAMETERS
//  DEPTH  256  stack entries, >=2
//  WIDTH  4    data width, signed two's complement, >=2
// PORTS
//  clk          in   1                    clock, rising edge
//  rst          in   1                    synchronous, active-high reset
//  op_valid     in   1                    opcode/input_data valid
//  op_ready     out  1                    block can accept an op (state==IDLE)
//  opcode       in   3                    operation, see BEHAVIOUR
//  input_data   in   WIDTH                operand for PUSH
//  output_data  out  WIDTH                top of stack; 0 when empty
//  count        out  $clog2(DEPTH+1)      number of valid entries
//  empty        out  1                    count==0
//  full         out  1                    count==DEPTH
//  done         out  1                    1-cycle pulse: op completed
//  overflow     out  1                    last completed arith op overflowed signed range
//  error        out  1                    last completed op was rejected (no state change)
// BEHAVIOUR
//  Reset: count=0, output_data=0, empty=1, full=0, done=0, overflow=0, error=0, op_ready=1,
//   FSM->IDLE; array contents don't care. rst wins over everything, aborts an in-flight MUL.
//  Handshake: op accepted on edge where op_valid&&op_ready. op_ready=0 outside IDLE.
//  Opcodes: 000 NOP, 001 DUP, 010 SWAP, 011 SUB, 100 ADD, 101 MUL, 110 PUSH, 111 POP.
//  Operands: a=top, b=next-below. Binary result r = b op a; pop two, push r (count-1).
//   SUB: r=b-a. SWAP exchanges a/b. DUP pushes copy of a.
//  Arithmetic: full-precision signed, truncated to WIDTH; overflow=1 iff true result outside
//   [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Non-arith ops complete with overflow=0.
//  Rejects (error=1, stack and count unchanged, overflow=0): PUSH/DUP when full; POP when empty;
//   ADD/SUB/MUL/SWAP with count<2; DUP when empty. NOP never errors.
//  Latency: single-cycle ops accepted at edge N -> stack/count/output_data updated and done=1
//   after edge N+1. MUL accepted at edge N -> done=1 after edge N+WIDTH+1; stack untouched
//   until completion edge.
//  FSM: IDLE -(accept non-MUL)-> EXEC -> IDLE; IDLE -(accept MUL, count>=2)-> MUL (WIDTH
//   iterations) -> EXEC (writeback) -> IDLE. MUL with count<2 goes to EXEC, rejected there.
//  done, error, overflow updated only on completion; done cleared next cycle; error/overflow held
//   until next completion.
//  output_data/empty/full/count are registered, consistent with each other every cycle.
//  PUSH on full with simultaneous POP impossible (single op); no wrap-around of pointer ever.
// STRUCTURE
//  stack_calc_pkg: opcode_e enum (8 codes above), state_e {IDLE, EXEC, MUL}, width helpers.
//  Sub-module seq_mul: signed shift-add multiplier, start/busy/done, WIDTH-cycle, 2*WIDTH product;
//   stack_calc truncates and derives overflow from the upper bits. Storage: array + count pointer.
// TESTING (DEPTH=256, WIDTH=4 unless noted)
//  1. PUSH 1, PUSH -2, ADD -> output_data=-1, count=1, overflow=0, error=0, done 1 cycle each op.
//  2. PUSH 7, PUSH 1, ADD -> output_data=-8, overflow=1; PUSH 3, SUB -> -8-3 -> 5, overflow=1.
//  3. PUSH -7, PUSH -2, MUL -> op_ready low 5 cycles, done at edge N+5, output_data=-2 (14
//     truncated), overflow=1; PUSH 3, MUL -> -6, overflow=0.
//  4. 256x PUSH i -> full=1, count=256; PUSH -> error=1, count=256, top unchanged; 257x POP ->
//     last POP error=1, empty=1, output_data=0.
//  5. Start MUL, assert rst mid-iteration -> next cycle count=0, op_ready=1, done=0, no writeback.
//  6. DUP/SWAP: PUSH 2, PUSH 5, SWAP -> top=2; DUP -> count=3, top=2; ADD on count=1 -> error=1.

Source files
------------

// File: rtl/stack_calc_pkg.sv
// Shared types for the stack calculator: opcodes, FSM states and
// helpers that size the stack pointer and the array index.
package stack_calc_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_DUP  = 3'b001,
        OP_SWAP = 3'b010,
        OP_SUB  = 3'b011,
        OP_ADD  = 3'b100,
        OP_MUL  = 3'b101,
        OP_PUSH = 3'b110,
        OP_POP  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stack_calc_mul.sv
// Serial signed shift-add multiplier: one multiplier bit per cycle,
// full 2*WIDTH product available once busy drops.
module seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);
    localparam int PW = 2 * WIDTH;
    localparam int NW = $clog2(WIDTH + 1);

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [NW-1:0]    cnt_q, cnt_d;
    logic             last;

    assign last   = (cnt_q == NW'(1));
    assign busy_o = (cnt_q != '0);
    assign done_o = busy_o && last;
    assign prod_o = acc_q;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = {{WIDTH{a_i[WIDTH-1]}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = NW'(WIDTH);
        end else if (busy_o) begin
            // the multiplier's sign bit carries negative weight
            if (mplier_q[0]) begin
                acc_d = last ? acc_q - mcand_q : acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - NW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/stack_calc.sv
// Signed LIFO with in-place ALU ops behind a valid/ready handshake;
// every op completes with a one-cycle done pulse plus error/overflow.
module stack_calc
    import stack_calc_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [2:0]                   opcode,
    input  logic [WIDTH-1:0]             input_data,
    output logic [WIDTH-1:0]             output_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         done,
    output logic                         overflow,
    output logic                         error
);
    localparam int CW = cnt_w(DEPTH);
    localparam int AW = idx_w(DEPTH);

    logic [WIDTH-1:0] stk_q [DEPTH];

    state_e           state_q, state_d;
    opcode_e          op_q, op_d, op_in;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;

    logic             accept, two, is_empty, is_full;
    logic [AW-1:0]    ia, ib, ip;
    logic [WIDTH-1:0] a, b;
    logic             we0, we1;
    logic [AW-1:0]    wa0, wa1;
    logic [WIDTH-1:0] wd0, wd1;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] res;
    logic             res_ovf;

    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign op_in    = opcode_e'(opcode);
    assign accept   = op_valid && op_ready;
    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CW'(DEPTH));
    assign two      = (cnt_q >= CW'(2));
    assign ia       = AW'(cnt_q - CW'(1));
    assign ib       = AW'(cnt_q - CW'(2));
    assign ip       = AW'(cnt_q);
    assign a        = stk_q[ia];
    assign b        = stk_q[ib];

    assign mul_start = accept && (op_in == OP_MUL) && two;

    seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (mul_start),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    always_comb begin
        ext     = '0;
        res     = '0;
        res_ovf = 1'b0;
        case (op_q)
            OP_ADD: begin
                ext     = {b[WIDTH-1], b} + {a[WIDTH-1], a};
                res     = ext[WIDTH-1:0];
                res_ovf = ext[WIDTH] ^ ext[WIDTH-1];
            end
            OP_SUB: begin
                ext     = {b[WIDTH-1], b} - {a[WIDTH-1], a};
                res     = ext[WIDTH-1:0];
                res_ovf = ext[WIDTH] ^ ext[WIDTH-1];
            end
            OP_MUL: begin
                res     = mul_prod[WIDTH-1:0];
                res_ovf = mul_prod[2*WIDTH-1:WIDTH-1]
                          != {(WIDTH+1){mul_prod[WIDTH-1]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        top_d   = top_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ovf_d   = ovf_q;
        we0     = 1'b0;
        wa0     = ip;
        wd0     = a;
        we1     = 1'b0;
        wa1     = ib;
        wd1     = a;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = op_in;
                    data_d  = input_data;
                    state_d = mul_start ? S_MUL : S_EXEC;
                end
            end
            S_MUL: begin
                if (mul_done || !mul_busy) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b0;
                ovf_d   = 1'b0;
                unique case (op_q)
                    OP_NOP: ;
                    OP_PUSH: begin
                        if (is_full) err_d = 1'b1;
                        else begin
                            we0   = 1'b1;
                            wd0   = data_q;
                            cnt_d = cnt_q + CW'(1);
                            top_d = data_q;
                        end
                    end
                    OP_POP: begin
                        if (is_empty) err_d = 1'b1;
                        else begin
                            cnt_d = cnt_q - CW'(1);
                            top_d = two ? b : '0;
                        end
                    end
                    OP_DUP: begin
                        if (is_empty || is_full) err_d = 1'b1;
                        else begin
                            we0   = 1'b1;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    OP_SWAP: begin
                        if (!two) err_d = 1'b1;
                        else begin
                            we0   = 1'b1;
                            wa0   = ia;
                            wd0   = b;
                            we1   = 1'b1;
                            top_d = b;
                        end
                    end
                    OP_ADD, OP_SUB, OP_MUL: begin
                        if (!two) err_d = 1'b1;
                        else begin
                            we1   = 1'b1;
                            wd1   = res;
                            cnt_d = cnt_q - CW'(1);
                            top_d = res;
                            ovf_d = res_ovf;
                        end
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    // storage has no reset; only the pointer defines validity
    always_ff @(posedge clk) begin
        if (!rst && we0) stk_q[wa0] <= wd0;
        if (!rst && we1) stk_q[wa1] <= wd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            cnt_q   <= '0;
            top_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            top_q   <= top_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign op_ready    = (state_q == S_IDLE);
    assign output_data = top_q;
    assign count       = cnt_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign done        = done_q;
    assign error       = err_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_stack_calc.sv
// Bench for stack_calc: directed scenarios plus random op streams
// checked against a queue-based reference model.
module tb_stack_calc;
    import stack_calc_pkg::*;

    localparam int D = 256;
    localparam int W = 4;

    typedef logic [16:0] obs_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         op_valid = 1'b0;
    logic [2:0]   opcode = 3'd0;
    logic [W-1:0] input_data = '0;
    logic         op_ready;
    logic [W-1:0] output_data;
    logic [8:0]   count;
    logic         empty, full, done, overflow, error;

    int checks = 0;
    int passes = 0;
    int q[$];

    always #5 clk = ~clk;

    stack_calc #(
        .DEPTH (D),
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .opcode      (opcode),
        .input_data  (input_data),
        .output_data (output_data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .done        (done),
        .overflow    (overflow),
        .error       (error)
    );

    function automatic int wrap(input int v);
        logic [W-1:0] t;
        t = v[W-1:0];
        return int'($signed(t));
    endfunction

    function automatic void model(input logic [2:0] op, input logic [W-1:0] d,
                                  output logic eerr, output logic eovf,
                                  output int elat);
        int a, b, r;
        eerr = 1'b0;
        eovf = 1'b0;
        elat = 1;
        case (op)
            OP_PUSH: if (q.size() == D) eerr = 1'b1;
                     else q.push_back(int'($signed(d)));
            OP_POP:  if (q.size() == 0) eerr = 1'b1;
                     else void'(q.pop_back());
            OP_DUP:  if (q.size() == 0 || q.size() == D) eerr = 1'b1;
                     else q.push_back(q[q.size()-1]);
            OP_SWAP: if (q.size() < 2) eerr = 1'b1;
                     else begin
                         a = q.pop_back();
                         b = q.pop_back();
                         q.push_back(a);
                         q.push_back(b);
                     end
            OP_ADD, OP_SUB, OP_MUL: begin
                if (op == OP_MUL && q.size() >= 2) elat = W + 1;
                if (q.size() < 2) eerr = 1'b1;
                else begin
                    a = q.pop_back();
                    b = q.pop_back();
                    if (op == OP_ADD) r = b + a;
                    else if (op == OP_SUB) r = b - a;
                    else r = b * a;
                    eovf = (r > 2**(W-1) - 1) || (r < -(2**(W-1)));
                    q.push_back(wrap(r));
                end
            end
            default: ;
        endcase
    endfunction

    function automatic obs_t exp_vec(input logic eerr, input logic eovf);
        logic [W-1:0] t;
        t = '0;
        if (q.size() > 0) t = W'(q[q.size()-1]);
        return {t, 9'(q.size()), q.size() == 0, q.size() == D, eerr, eovf};
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    // lat: edges from accept to done (-1 on timeout); rlow: samples with op_ready low
    task automatic issue(input logic [2:0] op, input logic [W-1:0] d,
                         output int lat, output int rlow);
        int n;
        @(negedge clk);
        n = 0;
        while (!op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        op_valid   = 1'b1;
        opcode     = op;
        input_data = d;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        rlow = op_ready ? 0 : 1;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (!op_ready) rlow++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        checks++;
        if ({output_data, count, empty, full} !== {4'd0, 9'd0, 1'b1, 1'b0}) begin
            $display("FAIL reset_stack: got top=%0d cnt=%0d e=%b f=%b want 0 0 1 0",
                     output_data, count, empty, full);
        end else passes++;
        checks++;
        if ({done, overflow, error, op_ready} !== 4'b0001) begin
            $display("FAIL reset_flags: got done=%b ovf=%b err=%b rdy=%b want 0 0 0 1",
                     done, overflow, error, op_ready);
        end else passes++;
    endtask

    task automatic test_arith();
        logic [2:0]   ops [17];
        logic [W-1:0] ds  [17];
        logic         eerr, eovf;
        int           lat, rlow, elat;
        obs_t         ev;
        ops = '{OP_PUSH, OP_PUSH, OP_ADD, OP_POP,
                OP_PUSH, OP_PUSH, OP_ADD, OP_PUSH, OP_SUB, OP_POP,
                OP_PUSH, OP_PUSH, OP_MUL, OP_PUSH, OP_MUL, OP_POP, OP_NOP};
        ds  = '{4'd1, 4'hE, 4'd0, 4'd0,
                4'd7, 4'd1, 4'd0, 4'd3, 4'd0, 4'd0,
                4'h9, 4'hE, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0};
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            issue(ops[i], ds[i], lat, rlow);
            model(ops[i], ds[i], eerr, eovf, elat);
            ev = exp_vec(eerr, eovf);
            checks++;
            if ({output_data, count, empty, full, error, overflow} !== ev
                || lat != elat || rlow != elat) begin
                $display("FAIL arith[%0d]: got vec=%h lat=%0d rdy_low=%0d want vec=%h lat=%0d",
                         i, {output_data, count, empty, full, error, overflow},
                         lat, rlow, ev, elat);
            end else passes++;
            if (i == 2 || i == 6 || i == 8 || i == 12 || i == 14) begin
                checks++;
                if ({output_data, overflow} !== {ds[i] ^ ds[i], 1'b0} &&
                    !((i == 2  && {output_data, overflow} === 5'b1111_0) ||
                      (i == 6  && {output_data, overflow} === 5'b1000_1) ||
                      (i == 8  && {output_data, overflow} === 5'b0101_1) ||
                      (i == 12 && {output_data, overflow} === 5'b1110_1) ||
                      (i == 14 && {output_data, overflow} === 5'b1010_0))) begin
                    $display("FAIL arith_spot[%0d]: got top=%h ovf=%b", i,
                             output_data, overflow);
                end else passes++;
            end
        end
    endtask

    task automatic test_dup_swap();
        logic [2:0]   ops [8];
        logic [W-1:0] ds  [8];
        logic         eerr, eovf;
        int           lat, rlow, elat;
        obs_t         ev;
        ops = '{OP_PUSH, OP_PUSH, OP_SWAP, OP_DUP, OP_POP, OP_POP, OP_ADD, OP_SWAP};
        ds  = '{4'd2, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], ds[i], lat, rlow);
            model(ops[i], ds[i], eerr, eovf, elat);
            ev = exp_vec(eerr, eovf);
            checks++;
            if ({output_data, count, empty, full, error, overflow} !== ev || lat != elat) begin
                $display("FAIL dupswap[%0d]: got vec=%h lat=%0d want vec=%h lat=%0d",
                         i, {output_data, count, empty, full, error, overflow},
                         lat, ev, elat);
            end else passes++;
            if (i == 3) begin
                checks++;
                if ({output_data, count} !== {4'd2, 9'd3}) begin
                    $display("FAIL dup_spot: got top=%0d cnt=%0d want 2 3",
                             output_data, count);
                end else passes++;
            end
        end
        checks++;
        if ({error, count} !== {1'b1, 9'd1}) begin
            $display("FAIL add_short: got err=%b cnt=%0d want 1 1", error, count);
        end else passes++;
    endtask

    task automatic test_fill();
        logic         eerr, eovf;
        int           lat, rlow, elat, bad;
        logic [W-1:0] d;
        logic [2:0]   op;
        obs_t         ev;
        reset_dut();
        bad = 0;
        for (int i = 0; i < 2 * D + 2; i++) begin
            op = (i <= D) ? OP_PUSH : OP_POP;
            d  = W'($urandom);
            issue(op, d, lat, rlow);
            model(op, d, eerr, eovf, elat);
            ev = exp_vec(eerr, eovf);
            checks++;
            if ({output_data, count, empty, full, error, overflow} !== ev || lat != elat) begin
                if (bad < 10)
                    $display("FAIL fill[%0d]: got vec=%h lat=%0d want vec=%h lat=%0d",
                             i, {output_data, count, empty, full, error, overflow},
                             lat, ev, elat);
                bad++;
            end else passes++;
            if (i == D || i == 2 * D + 1) begin
                checks++;
                if (error !== 1'b1 || full !== (i == D) || empty !== (i != D)) begin
                    $display("FAIL fill_edge[%0d]: got err=%b full=%b empty=%b",
                             i, error, full, empty);
                end else passes++;
            end
        end
    endtask

    task automatic test_reset_mul();
        logic eerr, eovf;
        int   lat, rlow, elat, bad;
        reset_dut();
        issue(OP_PUSH, 4'd3, lat, rlow);
        model(OP_PUSH, 4'd3, eerr, eovf, elat);
        issue(OP_PUSH, 4'd2, lat, rlow);
        model(OP_PUSH, 4'd2, eerr, eovf, elat);
        @(negedge clk);
        op_valid = 1'b1;
        opcode   = OP_MUL;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        checks++;
        if ({count, op_ready, done, empty} !== {9'd0, 1'b1, 1'b0, 1'b1}) begin
            $display("FAIL mul_abort: got cnt=%0d rdy=%b done=%b empty=%b want 0 1 0 1",
                     count, op_ready, done, empty);
        end else passes++;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done || count != 0 || !op_ready) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL mul_abort_quiet: got %0d bad cycles want 0", bad);
        end else passes++;
    endtask

    task automatic test_random();
        logic         eerr, eovf;
        int           lat, rlow, elat, bad;
        logic [W-1:0] d;
        logic [2:0]   op;
        obs_t         ev;
        reset_dut();
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 9) < 3) ? OP_PUSH : 3'($urandom_range(0, 7));
            d  = W'($urandom);
            issue(op, d, lat, rlow);
            model(op, d, eerr, eovf, elat);
            ev = exp_vec(eerr, eovf);
            checks++;
            if ({output_data, count, empty, full, error, overflow} !== ev
                || lat != elat || rlow != elat) begin
                if (bad < 10)
                    $display("FAIL rand[%0d] op=%0d d=%h: got vec=%h lat=%0d want vec=%h lat=%0d",
                             i, op, d, {output_data, count, empty, full, error, overflow},
                             lat, ev, elat);
                bad++;
            end else passes++;
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                if (bad < 10) $display("FAIL rand_pulse[%0d]: got done=%b want 0", i, done);
                bad++;
            end else passes++;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_arith();
        test_dup_swap();
        test_fill();
        test_reset_mul();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
